via_bus_arbiter: RTL and testbench

//  Shares one MOS6522 register port between the 6502 CPU and a debug master (host/UART monitor).

---
 rtl/via_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_via_bus_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/via_bus_arbiter.sv
// Shares one 6522 VIA register port between the 6502 CPU and a debug master.
// CPU owns the port; debug uses idle slots or steals one after MAX_CPU_WIN CPU wins.
module via_bus_arbiter #(
  parameter int MAX_CPU_WIN = 4,
  parameter bit SAFE_READ   = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_en,
  input  logic       CPU_REQ,
  input  logic       CPU_RnW,
  input  logic [3:0] CPU_RS,
  input  logic [7:0] CPU_DIN,
  output logic [7:0] CPU_DOUT,
  output logic       CPU_READY,
  input  logic       DBG_REQ,
  input  logic       DBG_RnW,
  input  logic [3:0] DBG_RS,
  input  logic [7:0] DBG_DIN,
  output logic [7:0] DBG_DOUT,
  output logic       DBG_BUSY,
  output logic       DBG_ACK,
  output logic       DBG_ERR,
  output logic       VIA_CS,
  output logic       VIA_RnW,
  output logic [3:0] VIA_RS,
  output logic [7:0] VIA_DOUT,
  input  logic [7:0] VIA_DIN
);

  localparam int WW =
    (MAX_CPU_WIN < 1) ? 1 : $clog2(MAX_CPU_WIN + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_CPU_WIN);
  localparam bit STEAL_EN = (MAX_CPU_WIN != 0);

  logic          pending_q, pending_d;
  logic [WW-1:0] win_q, win_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [7:0]    dout_q, dout_d;
  logic          op_rnw_q, op_rnw_d;
  logic [3:0]    op_rs_q, op_rs_d;
  logic [7:0]    op_din_q, op_din_d;

  logic steal, cpu_g, dbg_g;
  logic accept, refuse, side_fx;

  // Slot arbitration and VIA pin mux for the current CLK_en cycle
  always_comb begin
    steal   = pending_q & STEAL_EN & (win_q == WMAX);
    cpu_g   = ~RESET & CLK_en & CPU_REQ & ~steal;
    dbg_g   = ~RESET & CLK_en & pending_q
            & (~CPU_REQ | steal);
    CPU_READY = ~(~RESET & CLK_en & CPU_REQ & steal);
    CPU_DOUT  = VIA_DIN;
    VIA_CS    = cpu_g | dbg_g;
    VIA_RnW   = 1'b1;
    VIA_RS    = 4'h0;
    VIA_DOUT  = 8'h00;
    unique case (1'b1)
      cpu_g: begin
        VIA_RnW  = CPU_RnW;
        VIA_RS   = CPU_RS;
        VIA_DOUT = CPU_DIN;
      end
      dbg_g: begin
        VIA_RnW  = op_rnw_q;
        VIA_RS   = op_rs_q;
        VIA_DOUT = op_din_q;
      end
      default: ;
    endcase
  end

  // Debug capture / refusal / completion and CPU win counting
  always_comb begin
    pending_d = pending_q;
    win_d     = win_q;
    ack_d     = 1'b0;
    err_d     = err_q;
    dout_d    = dout_q;
    op_rnw_d  = op_rnw_q;
    op_rs_d   = op_rs_q;
    op_din_d  = op_din_q;
    side_fx   = DBG_RS inside {4'h0, 4'h1, 4'h4,
                               4'h8, 4'hA, 4'hF};
    accept    = DBG_REQ & ~pending_q;
    refuse    = accept & SAFE_READ & DBG_RnW & side_fx;
    if (dbg_g) begin
      pending_d = 1'b0;
      ack_d     = 1'b1;
      err_d     = 1'b0;
      if (op_rnw_q) dout_d = VIA_DIN;
    end
    if (refuse) begin
      ack_d = 1'b1;
      err_d = 1'b1;
    end else if (accept) begin
      pending_d = 1'b1;
      op_rnw_d  = DBG_RnW;
      op_rs_d   = DBG_RS;
      op_din_d  = DBG_DIN;
    end
    if (~pending_q | dbg_g) begin
      win_d = '0;
    end else if (cpu_g && win_q != WMAX) begin
      win_d = win_q + WW'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q <= 1'b0;
      win_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= 8'h00;
      op_rnw_q  <= 1'b1;
      op_rs_q   <= 4'h0;
      op_din_q  <= 8'h00;
    end else begin
      pending_q <= pending_d;
      win_q     <= win_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      dout_q    <= dout_d;
      op_rnw_q  <= op_rnw_d;
      op_rs_q   <= op_rs_d;
      op_din_q  <= op_din_d;
    end
  end

  assign DBG_BUSY = pending_q;
  assign DBG_ACK  = ack_q;
  assign DBG_ERR  = err_q;
  assign DBG_DOUT = dout_q;

endmodule

// File: tb/tb_via_bus_arbiter.sv
// Scoreboard bench for via_bus_arbiter.
// Directed slots push expected VIA cycles and debug ACKs; a monitor pops them.
module tb_via_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CLK_en, CPU_REQ, CPU_RnW;
  logic [3:0] CPU_RS;
  logic [7:0] CPU_DIN, CPU_DOUT;
  logic       CPU_READY;
  logic       DBG_REQ, DBG_RnW;
  logic [3:0] DBG_RS;
  logic [7:0] DBG_DIN, DBG_DOUT;
  logic       DBG_BUSY, DBG_ACK, DBG_ERR;
  logic       VIA_CS, VIA_RnW;
  logic [3:0] VIA_RS;
  logic [7:0] VIA_DOUT, VIA_DIN;

  always #5 CLK = ~CLK;

  via_bus_arbiter dut (
    .CLK(CLK), .RESET(RESET), .CLK_en(CLK_en),
    .CPU_REQ(CPU_REQ), .CPU_RnW(CPU_RnW),
    .CPU_RS(CPU_RS), .CPU_DIN(CPU_DIN),
    .CPU_DOUT(CPU_DOUT), .CPU_READY(CPU_READY),
    .DBG_REQ(DBG_REQ), .DBG_RnW(DBG_RnW),
    .DBG_RS(DBG_RS), .DBG_DIN(DBG_DIN),
    .DBG_DOUT(DBG_DOUT), .DBG_BUSY(DBG_BUSY),
    .DBG_ACK(DBG_ACK), .DBG_ERR(DBG_ERR),
    .VIA_CS(VIA_CS), .VIA_RnW(VIA_RnW),
    .VIA_RS(VIA_RS), .VIA_DOUT(VIA_DOUT),
    .VIA_DIN(VIA_DIN)
  );

  typedef struct packed {
    logic       rnw;
    logic [3:0] rs;
    logic [7:0] dout;
    logic       rdy;
  } via_t;

  typedef struct packed {
    logic       err;
    logic [7:0] dout;
  } ack_t;

  via_t via_q[$];
  ack_t ack_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  task automatic pv(input logic rnw, input logic [3:0] rs,
                    input logic [7:0] d, input logic rdy);
    via_t e;
    e.rnw = rnw; e.rs = rs; e.dout = d; e.rdy = rdy;
    via_q.push_back(e);
  endtask

  task automatic pa(input logic err, input logic [7:0] d);
    ack_t e;
    e.err = err; e.dout = d;
    ack_q.push_back(e);
  endtask

  // Monitor: every VIA cycle and every ACK must match the next expectation
  always @(negedge CLK) begin
    via_t ve;
    ack_t ae;
    if (VIA_CS !== 1'b0) begin
      if (via_q.size() == 0) begin
        n_total++;
        $display("FAIL via_unexpected: got cs=%b rs=%0h want no cycle",
                 VIA_CS, VIA_RS);
      end else begin
        ve = via_q.pop_front();
        chk("via_cycle",
            32'({VIA_RnW, VIA_RS, VIA_DOUT, CPU_READY}),
            32'(ve));
        chk("cpu_dout", 32'(CPU_DOUT), 32'(VIA_DIN));
      end
    end
    if (DBG_ACK !== 1'b0) begin
      if (ack_q.size() == 0) begin
        n_total++;
        $display("FAIL ack_unexpected: got ack=%b want no ack",
                 DBG_ACK);
      end else begin
        ae = ack_q.pop_front();
        chk("dbg_ack", 32'({DBG_ERR, DBG_DOUT}), 32'(ae));
      end
    end
  end

  task automatic drive(input logic en, input logic creq,
                       input logic crnw, input logic [3:0] crs,
                       input logic [7:0] cdin,
                       input logic [7:0] vdin);
    CLK_en  = en;
    CPU_REQ = creq;
    CPU_RnW = crnw;
    CPU_RS  = crs;
    CPU_DIN = cdin;
    VIA_DIN = vdin;
    DBG_REQ = 1'b0;
  endtask

  task automatic dbg(input logic rnw, input logic [3:0] rs,
                     input logic [7:0] din);
    DBG_REQ = 1'b1;
    DBG_RnW = rnw;
    DBG_RS  = rs;
    DBG_DIN = din;
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b1;
    DBG_RnW = 1'b1; DBG_RS = 4'h0; DBG_DIN = 8'h00;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00);
    tick; tick;
    RESET = 1'b0;
    #1;
    chk("rst_busy", 32'(DBG_BUSY), 32'd0);
    chk("rst_ack", 32'(DBG_ACK), 32'd0);
    chk("rst_err", 32'(DBG_ERR), 32'd0);
    chk("rst_dout", 32'(DBG_DOUT), 32'h00);
    chk("rst_cs", 32'(VIA_CS), 32'd0);
    chk("rst_ready", 32'(CPU_READY), 32'd1);
    chk("rst_rnw", 32'(VIA_RnW), 32'd1);

    // T1: CPU-only traffic
    pv(1, 4'hD, 8'h00, 1);
    pv(1, 4'hD, 8'h00, 1);
    pv(0, 4'h2, 8'h5A, 1);
    drive(1, 1, 1, 4'hD, 8'h00, 8'h11); tick;
    drive(0, 1, 1, 4'hD, 8'h00, 8'h22); #1;
    chk("t1_ready_noslot", 32'(CPU_READY), 32'd1);
    chk("t1_cs_noslot", 32'(VIA_CS), 32'd0);
    tick;
    drive(1, 1, 1, 4'hD, 8'h00, 8'h33); tick;
    drive(1, 1, 0, 4'h2, 8'h5A, 8'h44); tick;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick;

    // T2: debug write in an idle slot
    pv(0, 4'h3, 8'hFF, 1);
    pa(0, 8'h00);
    dbg(0, 4'h3, 8'hFF); tick;
    chk("t2_busy", 32'(DBG_BUSY), 32'd1);
    drive(1, 0, 1, 4'h0, 8'h00, 8'h99); tick;
    chk("t2_busy_clr", 32'(DBG_BUSY), 32'd0);
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick; tick;

    // T3: steal after four CPU wins
    for (int i = 0; i < 4; i++) pv(1, 4'hD, 8'h00, 1);
    pv(1, 4'hE, 8'h00, 0);
    pv(1, 4'hD, 8'h00, 1);
    pa(0, 8'hC3);
    dbg(1, 4'hE, 8'h00); tick;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 1, 4'hD, 8'h00, 8'(i + 1)); tick;
    end
    drive(1, 1, 1, 4'hD, 8'h00, 8'hC3); #1;
    chk("t3_steal_ready", 32'(CPU_READY), 32'd0);
    tick;
    drive(1, 1, 1, 4'hD, 8'h00, 8'h3C); tick;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick;
    chk("t3_dbg_dout", 32'(DBG_DOUT), 32'hC3);

    // T4: refused side-effect read
    pa(1, 8'hC3);
    dbg(1, 4'h4, 8'h00); tick;
    chk("t4_busy", 32'(DBG_BUSY), 32'd0);
    drive(1, 0, 1, 4'h0, 8'h00, 8'h55); tick;
    chk("t4_err_held", 32'(DBG_ERR), 32'd1);
    chk("t4_ack_pulse", 32'(DBG_ACK), 32'd0);
    chk("t4_dout_kept", 32'(DBG_DOUT), 32'hC3);
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick;

    // T5: request while busy ignored; request in ACK cycle accepted
    pv(1, 4'h2, 8'h00, 1);
    pa(0, 8'h5C);
    pv(0, 4'h9, 8'h77, 1);
    pa(0, 8'h5C);
    dbg(1, 4'h2, 8'h00); tick;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00);
    dbg(0, 4'h7, 8'hAA); tick;
    chk("t5_busy", 32'(DBG_BUSY), 32'd1);
    drive(1, 0, 1, 4'h0, 8'h00, 8'h5C); tick;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00);
    dbg(0, 4'h9, 8'h77); tick;
    chk("t5_busy_ackcyc", 32'(DBG_BUSY), 32'd1);
    drive(1, 0, 1, 4'h0, 8'h00, 8'h66); tick;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick; tick;

    // T6: reset while an op is pending in a slot
    pv(1, 4'hD, 8'h00, 1);
    pv(1, 4'hD, 8'h00, 1);
    dbg(0, 4'h6, 8'h42); tick;
    drive(1, 1, 1, 4'hD, 8'h00, 8'h01); tick;
    drive(1, 1, 1, 4'hD, 8'h00, 8'h02); tick;
    RESET = 1'b1;
    drive(1, 0, 1, 4'h0, 8'h00, 8'h03); #1;
    chk("t6_cs_in_reset", 32'(VIA_CS), 32'd0);
    tick;
    RESET = 1'b0;
    chk("t6_busy", 32'(DBG_BUSY), 32'd0);
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick; tick;
    pv(1, 4'hD, 8'h00, 1);
    drive(1, 1, 1, 4'hD, 8'h00, 8'h04); #1;
    chk("t6_ready", 32'(CPU_READY), 32'd1);
    tick;
    drive(0, 0, 1, 4'h0, 8'h00, 8'h00); tick; tick;

    chk("via_q_drained", 32'(via_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
